// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: funct3 encodings, LSU state, byte-enable
// patterns and the bus payload captured when the LSU accepts a request.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
    localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
    localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } lsu_bus_t;

    // Legal encoding for the access direction and natural alignment for the size.
    function automatic logic access_legal(input logic is_store, input logic [2:0] f3,
                                          input logic [1:0] lo);
        logic ok_f3;
        logic aligned;
        if (is_store) ok_f3 = (f3 == FUNCT3_SB) || (f3 == FUNCT3_SH) || (f3 == FUNCT3_SW);
        else          ok_f3 = (f3 == FUNCT3_LB) || (f3 == FUNCT3_LH) || (f3 == FUNCT3_LW) ||
                              (f3 == FUNCT3_LBU) || (f3 == FUNCT3_LHU);
        case (f3[1:0])
            2'b01:   aligned = ~lo[0];
            2'b10:   aligned = (lo == 2'b00);
            default: aligned = 1'b1;
        endcase
        return ok_f3 && aligned;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword lane of a read word and extends it to XLEN.
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] load_data_c
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            FUNCT3_LB:  load_data_c = {{24{byte_lane[7]}}, byte_lane};
            FUNCT3_LH:  load_data_c = {{16{half_lane[15]}}, half_lane};
            FUNCT3_LBU: load_data_c = {24'd0, byte_lane};
            FUNCT3_LHU: load_data_c = {16'd0, half_lane};
            default:    load_data_c = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding access on a req/gnt/rvalid memory bus,
// with lane steering for stores and extraction/extension for loads.
module lsu
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic        lsu_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    lsu_state_t      state_q, state_d;
    lsu_bus_t        bus_q, bus_d;
    logic [2:0]      funct3_q;
    logic [1:0]      addr_lo_q;
    logic            req_c, legal_c, capture_c, load_cap_c, err_c;
    logic [XLEN-1:0] aligned_c;

    // Request decode; a write wins when both strobes are high.
    always_comb begin
        req_c       = mem_read | mem_write;
        legal_c     = access_legal(mem_write, funct3, addr[1:0]);
        bus_d       = '0;
        bus_d.we    = mem_write;
        bus_d.addr  = {addr[31:2], 2'b00};
        case (funct3[1:0])
            2'b00: begin
                bus_d.be    = BE_BYTE << addr[1:0];
                bus_d.wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                bus_d.be    = BE_HALF << addr[1:0];
                bus_d.wdata = {2{store_data[15:0]}};
            end
            default: begin
                bus_d.be    = BE_WORD;
                bus_d.wdata = store_data;
            end
        endcase
        if (!mem_write) bus_d.wdata = '0;
    end

    always_comb begin
        state_d    = state_q;
        lsu_busy   = 1'b0;
        capture_c  = 1'b0;
        load_cap_c = 1'b0;
        err_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_c && !rst) begin
                    if (legal_c) begin
                        capture_c = 1'b1;
                        lsu_busy  = 1'b1;
                        state_d   = REQ;
                    end else begin
                        err_c = 1'b1;
                    end
                end
            end
            REQ: begin
                lsu_busy = 1'b1;
                if (bus_gnt) begin
                    if (bus_q.we) begin
                        state_d = DONE;
                    end else if (bus_rvalid) begin
                        load_cap_c = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                lsu_busy = 1'b1;
                if (bus_rvalid) begin
                    load_cap_c = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bus_q     <= '0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            load_data <= '0;
            lsu_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            lsu_err <= err_c;
            if (capture_c) begin
                bus_q     <= bus_d;
                funct3_q  <= funct3;
                addr_lo_q <= addr[1:0];
            end
            if (load_cap_c) load_data <= aligned_c;
        end
    end

    lsu_load_align u_align (
        .funct3      (funct3_q),
        .addr_lo     (addr_lo_q),
        .rdata       (bus_rdata),
        .load_data_c (aligned_c)
    );

    // Bus fields are only driven while the request is outstanding.
    always_comb begin
        lsu_done  = (state_q == DONE);
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_be    = '0;
        bus_wdata = '0;
        if (state_q == REQ) begin
            bus_req   = 1'b1;
            bus_we    = bus_q.we;
            bus_addr  = bus_q.addr;
            bus_be    = bus_q.be;
            bus_wdata = bus_q.wdata;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed table-driven bench for the LSU plus hand-written reset sequences.
module tb_lsu;

    logic        clk, rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [31:0] load_data;
    logic        lsu_busy, lsu_done, lsu_err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    lsu dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .load_data(load_data), .lsu_busy(lsu_busy), .lsu_done(lsu_done),
        .lsu_err(lsu_err), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          gw;     // REQ cycles with gnt low
        int          rw;     // WAIT cycles up to and including rvalid (0: with gnt)
        logic        err;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ldata;
        int          lat;    // cycles from request to lsu_done
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    int          total  = 0;
    int          passed = 0;
    logic [31:0] last_ld = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic idle_inputs();
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'd0;
        addr       = 32'd0;
        store_data = 32'd0;
    endtask

    task automatic check_bus(input vec_t v, input string tag);
        chk({tag, "_req"},   32'(bus_req),  32'd1);
        chk({tag, "_busy"},  32'(lsu_busy), 32'd1);
        chk({tag, "_we"},    32'(bus_we),   32'(v.wr));
        chk({tag, "_addr"},  bus_addr,      v.baddr);
        chk({tag, "_be"},    32'(bus_be),   32'(v.be));
        chk({tag, "_wdata"}, bus_wdata,     v.wdata);
    endtask

    task automatic run_vec(input vec_t v);
        int   lat;
        logic is_ld;
        is_ld = !v.wr;
        @(posedge clk); #1;
        mem_read = v.rd; mem_write = v.wr; funct3 = v.f3; addr = v.addr; store_data = v.sd;
        @(negedge clk);
        if (v.err) begin
            chk("err_busy", 32'(lsu_busy), 32'd0);
            @(posedge clk); #1; idle_inputs();
            @(negedge clk);
            chk("err_pulse",   32'(lsu_err),  32'd1);
            chk("err_bus_req", 32'(bus_req),  32'd0);
            chk("err_busy2",   32'(lsu_busy), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("err_clear",    32'(lsu_err), 32'd0);
            chk("err_bus_req2", 32'(bus_req), 32'd0);
            chk("err_no_done",  32'(lsu_done), 32'd0);
            return;
        end
        chk("accept_busy", 32'(lsu_busy), 32'd1);
        chk("accept_no_req", 32'(bus_req), 32'd0);
        @(posedge clk); #1; idle_inputs(); lat = 1;
        for (int k = 0; k < v.gw; k++) begin
            bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_BAD0;
            @(negedge clk); check_bus(v, "req_hold");
            @(posedge clk); #1; lat++;
        end
        bus_gnt    = 1'b1;
        bus_rvalid = is_ld && (v.rw == 0);
        bus_rdata  = (v.rw == 0) ? v.rdata : 32'hBAD1_BAD1;
        @(negedge clk); check_bus(v, "req_gnt");
        @(posedge clk); #1; bus_gnt = 1'b0; bus_rvalid = 1'b0; lat++;
        if (is_ld) begin
            for (int k = 1; k <= v.rw; k++) begin
                bus_rvalid = (k == v.rw);
                bus_rdata  = (k == v.rw) ? v.rdata : 32'hBAD2_BAD2;
                @(negedge clk);
                chk("wait_busy",    32'(lsu_busy), 32'd1);
                chk("wait_no_req",  32'(bus_req),  32'd0);
                chk("wait_no_done", 32'(lsu_done), 32'd0);
                @(posedge clk); #1; bus_rvalid = 1'b0; lat++;
            end
        end
        bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_0000;
        @(negedge clk);
        chk("done_pulse",   32'(lsu_done), 32'd1);
        chk("done_busy",    32'(lsu_busy), 32'd0);
        chk("done_bus_req", 32'(bus_req),  32'd0);
        chk("latency",      32'(lat),      32'(v.lat));
        if (is_ld) last_ld = v.ldata;
        chk("load_data", load_data, last_ld);
        @(posedge clk); #1; bus_rvalid = 1'b0;
        @(negedge clk);
        chk("done_clear", 32'(lsu_done), 32'd0);
        chk("load_hold",  load_data,     last_ld);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 1, 1'b0,
                     32'h0000_0100, 4'b1000, 32'h0, 32'hFFFF_FF80, 3};
        vecs[1]  = '{1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 0, 0, 1'b0,
                     32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0, 2};
        vecs[2]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0101, 32'h0, 32'h0, 0, 0, 1'b1,
                     32'h0, 4'b0000, 32'h0, 32'h0, 0};
        vecs[3]  = '{1'b0, 1'b1, 3'd2, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0, 5, 0, 1'b0,
                     32'h0000_0300, 4'b1111, 32'hDEAD_BEEF, 32'h0, 7};
        vecs[4]  = '{1'b1, 1'b0, 3'd5, 32'h0000_0002, 32'h0, 32'h8001_0000, 0, 0, 1'b0,
                     32'h0000_0000, 4'b1100, 32'h0, 32'h0000_8001, 2};
        vecs[5]  = '{1'b1, 1'b0, 3'd1, 32'h0000_0006, 32'h0, 32'h8001_0000, 1, 2, 1'b0,
                     32'h0000_0004, 4'b1100, 32'h0, 32'hFFFF_8001, 5};
        vecs[6]  = '{1'b1, 1'b0, 3'd4, 32'h0000_0001, 32'h0, 32'h1234_80AA, 0, 1, 1'b0,
                     32'h0000_0000, 4'b0010, 32'h0, 32'h0000_0080, 3};
        vecs[7]  = '{1'b0, 1'b1, 3'd0, 32'h0000_0003, 32'h0000_00A5, 32'h0, 0, 0, 1'b0,
                     32'h0000_0000, 4'b1000, 32'hA5A5_A5A5, 32'h0, 2};
        vecs[8]  = '{1'b0, 1'b1, 3'd1, 32'h0000_0001, 32'h0, 32'h0, 0, 0, 1'b1,
                     32'h0, 4'b0000, 32'h0, 32'h0, 0};
        vecs[9]  = '{1'b1, 1'b0, 3'd3, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 1'b1,
                     32'h0, 4'b0000, 32'h0, 32'h0, 0};
        vecs[10] = '{1'b0, 1'b1, 3'd4, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 1'b1,
                     32'h0, 4'b0000, 32'h0, 32'h0, 0};
        vecs[11] = '{1'b1, 1'b1, 3'd2, 32'h0000_0010, 32'h55AA_55AA, 32'h0, 0, 0, 1'b0,
                     32'h0000_0010, 4'b1111, 32'h55AA_55AA, 32'h0, 2};
        vecs[12] = '{1'b1, 1'b0, 3'd2, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0,
                     32'h0000_0020, 4'b1111, 32'h0, 32'hCAFE_F00D, 2};
        vecs[13] = '{1'b1, 1'b0, 3'd0, 32'h0000_0100, 32'h0, 32'h0000_007F, 0, 1, 1'b0,
                     32'h0000_0100, 4'b0001, 32'h0, 32'h0000_007F, 3};

        rst = 1'b1; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_load_data", load_data,        32'd0);
        chk("rst_busy",      32'(lsu_busy),    32'd0);
        chk("rst_done",      32'(lsu_done),    32'd0);
        chk("rst_err",       32'(lsu_err),     32'd0);
        chk("rst_bus_req",   32'(bus_req),     32'd0);
        chk("rst_bus_addr",  bus_addr,         32'd0);
        chk("rst_bus_be",    32'(bus_be),      32'd0);
        @(posedge clk); #1; rst = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        // Reset while waiting for read data; the late rvalid must be dropped.
        @(posedge clk); #1; mem_read = 1'b1; funct3 = 3'd2; addr = 32'h0000_0040;
        @(posedge clk); #1; idle_inputs(); bus_gnt = 1'b1;
        @(posedge clk); #1; bus_gnt = 1'b0;
        @(negedge clk); chk("rstw_in_wait", 32'(lsu_busy), 32'd1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rstw_load_data", load_data,     32'd0);
        chk("rstw_busy",      32'(lsu_busy), 32'd0);
        chk("rstw_done",      32'(lsu_done), 32'd0);
        @(posedge clk); #1; bus_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rstw_no_done", 32'(lsu_done), 32'd0);
            chk("rstw_hold",    load_data,     32'd0);
        end

        // Reset while the request is outstanding.
        @(posedge clk); #1; mem_write = 1'b1; funct3 = 3'd2; addr = 32'h0000_0050;
        store_data = 32'h0BAD_F00D;
        @(posedge clk); #1; idle_inputs();
        @(negedge clk); chk("rstr_req", 32'(bus_req), 32'd1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; bus_gnt = 1'b1;
        @(negedge clk);
        chk("rstr_bus_req",  32'(bus_req),  32'd0);
        chk("rstr_bus_data", bus_wdata,     32'd0);
        chk("rstr_busy",     32'(lsu_busy), 32'd0);
        @(posedge clk); #1; bus_gnt = 1'b0;
        @(negedge clk); chk("rstr_no_done", 32'(lsu_done), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL use synchronous active-high reset; ports clk and rst follow the codebase naming.
REQ-002 SHALL expose these ports (name, direction, width, meaning):
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  load request, from the control unit.
- mem_write  in  1  store request, from the control unit.
- funct3  in  3  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW).
- addr  in  32  byte address (ALU result).
- store_data  in  32  rs2 value.
- load_data  out  32  extended load result, registered.
- lsu_busy  out  1  pipeline stall request.
- lsu_done  out  1  one-cycle completion pulse.
- lsu_err  out  1  one-cycle pulse: misaligned address or illegal funct3.
- bus_req  out  1  memory request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address; {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read data word.

Function
REQ-003 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-004 IDLE with a legal request (mem_read|mem_write) SHALL capture addr, funct3, store_data and request type, assert lsu_busy combinationally in the same cycle, and go to REQ.
REQ-005 When mem_read and mem_write are both high, mem_write SHALL win.
REQ-006 Misaligned (halfword with addr[0]=1; word with addr[1:0]!=0) or illegal funct3 (load 3/6/7; store >2) in IDLE SHALL pulse lsu_err for 1 cycle, start no bus transaction, keep lsu_busy=0, and stay in IDLE.
REQ-007 REQ SHALL hold bus_req=1 with bus_we/bus_addr/bus_be/bus_wdata stable until bus_gnt=1.
REQ-008 On gnt, a store SHALL go to DONE and a load SHALL go to WAIT; gnt together with rvalid on a load SHALL capture the data and go directly to DONE.
REQ-009 WAIT SHALL capture on bus_rvalid=1 and go to DONE; rvalid in IDLE/REQ-without-gnt/DONE SHALL be ignored.
REQ-010 DONE SHALL pulse lsu_done, drive lsu_busy=0, ignore inputs, and return to IDLE.
REQ-011 lsu_busy SHALL be 1 in REQ and WAIT and 0 in DONE; load-to-done minimum latency is 2 cycles after acceptance.
REQ-012 Byte enables: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<addr[1:0]; SW = 4'b1111.
REQ-013 bus_wdata: SB = {4{sd[7:0]}}; SH = {2{sd[15:0]}}; SW = sd.
REQ-014 Load extract: byte lane addr[1:0], halfword lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-015 load_data SHALL hold its value until the next load completes; stores SHALL NOT alter it.
REQ-016 Bus outputs outside REQ SHALL be 0.

Reset
REQ-017 rst SHALL force IDLE and zero every output, with load_data=0 and bus_req=0 from the next edge.
REQ-018 rst in REQ or WAIT SHALL abandon the transaction with no lsu_done pulse; a late rvalid SHALL be ignored.

Structure
REQ-019 riscv_pkg SHALL hold lsu_state_t and the BE_BYTE/BE_HALF/BE_WORD constants, and SHALL reuse the existing FUNCT3 load/store constants.
REQ-020 Combinational extraction/extension SHALL be sub-module lsu_load_align.

Verification
REQ-021 LB at addr 0x103, rdata 0x80FF_0000 with gnt immediate and rvalid next cycle -> load_data 0xFFFF_FF80, lsu_done 3 cycles after the request.
REQ-022 SH at addr 0x202, store_data 0x1234_ABCD -> bus_addr 0x200, bus_be 4'b1100, bus_wdata 0xABCD_ABCD, bus_we=1.
REQ-023 LW at addr 0x101 -> lsu_err for 1 cycle, bus_req never asserted, lsu_busy=0.
REQ-024 bus_gnt held low for 5 cycles on SW -> bus_req and all bus fields stable 5 cycles, lsu_busy=1 throughout.
REQ-025 LHU at addr 0x002 with gnt and rvalid in the same cycle, rdata 0x8001_0000 -> load_data 0x0000_8001, DONE next cycle.
REQ-026 rst asserted in WAIT, then rvalid=1 -> IDLE, load_data=0, no lsu_done pulse.
